leaf_output_packetizer: RTL and testbench
=========================================

Name: leaf_output_packetizer

Overview:
- Output-side stage of the leaf shell. Sits between the user kernel's output streams and the BFT output link.
- Round-robin arbitrates NUM_OUT_PORTS 32-bit user streams and tracks per-port destination credit.
- Stamps each word with destination leaf, port and write address, then registers one 49-bit packet toward the BFT.
- Runs entirely in the 400 MHz network clock domain.

Parameters:
- PACKET_BITS, 49, packet width; equals 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS.
- PAYLOAD_BITS, 32, user data width.
- NUM_LEAF_BITS, 5, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, destination write-address field width.
- NUM_OUT_PORTS, 2, number of user output streams (1..8).
- NUM_BRAM_ADDR_BITS, 7, log2 of destination buffer depth.
- FREESPACE_UPDATE_SIZE, 64, credits returned per freespace update.

Ports:
- clk  in  1  network clock (400 MHz).
- reset  in  1  synchronous, active-high.
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  user data; port i at slice i.
- vld_user2interface  in  NUM_OUT_PORTS  per-port data valid.
- ack_interface2user  out  NUM_OUT_PORTS  per-port accept; a word transfers when vld & ack.
- dest_leaf_cfg  in  NUM_OUT_PORTS*NUM_LEAF_BITS  static destination leaf per port.
- dest_port_cfg  in  NUM_OUT_PORTS*NUM_PORT_BITS  static destination port per port.
- freespace_vld  in  1  credit return pulse.
- freespace_port  in  NUM_PORT_BITS  local output port index receiving the credits.
- bft_ready  in  1  BFT accepts the presented packet this cycle.
- resend  in  1  link resend/hold.
- dout_leaf_interface2bft  out  PACKET_BITS  packet to BFT; all zeros when idle.
- credit_err  out  1  sticky flag for credit overflow or out-of-range port.

Behaviour:
- Packet format:
  - [48] valid
  - [47:43] dest leaf
  - [42:39] dest port
  - [38:32] write address
  - [31:0] payload
- Reset (synchronous):
  - Output register cleared, so dout is 0.
  - ack is 0, credit_err is 0.
  - Every credit counter is set to 2^NUM_BRAM_ADDR_BITS (128).
  - Every address counter is 0 and the RR pointer is 0.
  - Reset asserted mid-operation discards any held packet.
- Credit counter:
  - Width NUM_BRAM_ADDR_BITS+1 per port.
  - A port is eligible when vld[i]=1 and credit[i]!=0.
- Load condition: load_ok = !resend & (!out_valid | bft_ready).
- Arbitration:
  - Grants occur only when load_ok.
  - Search starts at the RR pointer and wraps upward; at most one grant per cycle.
  - ack = grant, combinational from registered state plus vld.
  - After a grant to port i, the pointer becomes (i+1) mod NUM_OUT_PORTS.
  - With no grant, the pointer holds.
- Latency: a word accepted in cycle t appears on dout in cycle t+1.
- Output register:
  - Loads the granted packet.
  - Clears to 0 when bft_ready & !resend and there is no grant.
  - Otherwise holds.
- Packet stamping: the address field is addr_cnt[i]. The counter then increments and wraps 127 to 0.
- Credits:
  - A grant decrements credit[i].
  - freespace_vld adds FREESPACE_UPDATE_SIZE to the credit of freespace_port.
  - Both in the same cycle on the same port: net change is +FREESPACE_UPDATE_SIZE-1.
  - A result above 128 clamps to 128 and sets credit_err.
  - freespace_port >= NUM_OUT_PORTS is ignored and sets credit_err.
- Resend:
  - While resend=1, dout is forced to 0, no grants, and the register and counters hold.
  - When resend drops, the held packet is presented again.
- Configuration: dest_leaf_cfg and dest_port_cfg are sampled at grant time. Changing them while traffic is in flight affects only later packets.

Decomposition:
- Shared package leaf_pkg holds:
  - field widths and bit offsets of the packet fields
  - the CREDIT_INIT constant
  - a function that packs a packet from its fields
- One sub-module, rr_arbiter_n: parameterised round-robin with request, enable, grant (one-hot) and pointer update.

Test Plan:
- Single port:
  - Stimulus: after reset, port 0 vld with data 0xA5A5_0001, dest leaf 3, port 2, bft_ready=1.
  - Response: ack0 in cycle t; dout = {1, 5'd3, 4'd2, 7'd0, 0xA5A50001} in cycle t+1; next word carries address 1.
- Round-robin:
  - Stimulus: both ports vld continuously.
  - Response: grants alternate 0,1,0,1; each port sees addresses 0,1,2… independently.
- Credit exhaustion:
  - Stimulus: port 0 sends 128 words with no freespace.
  - Response: ack0 stays 0 after word 128.
  - Stimulus: one freespace_vld on port 0.
  - Response: exactly 64 more words accepted; address wraps 127 to 0 on word 129.
- Backpressure and resend:
  - Stimulus: bft_ready=0 with a packet held.
  - Response: no acks; dout is stable.
  - Stimulus: resend=1 for 3 cycles.
  - Response: dout is 0.
  - Stimulus: resend=0.
  - Response: the same packet reappears; it is removed once bft_ready=1.
- Simultaneous grant and freespace:
  - Stimulus: port 1 credit at 10, grant and freespace_vld in the same cycle.
  - Response: credit becomes 73.
  - Stimulus: a further update with credit at 100.
  - Response: credit clamps to 128 and credit_err=1.
- Reset mid-stream:
  - Stimulus: assert reset while a packet is held.
  - Response: dout=0, credits=128, addresses=0, pointer=0 on the next cycle.

Source files
------------

// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf output packetizer: packet field layout,
// credit constants and the packet packing helper.
package leaf_pkg;

  localparam int PAYLOAD_BITS       = 32;
  localparam int NUM_LEAF_BITS      = 5;
  localparam int NUM_PORT_BITS      = 4;
  localparam int NUM_ADDR_BITS      = 7;
  localparam int PACKET_BITS        = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;

  // Bit offsets of the packet fields, LSB first.
  localparam int PAYLOAD_LSB        = 0;
  localparam int ADDR_LSB           = PAYLOAD_LSB + PAYLOAD_BITS;
  localparam int PORT_LSB           = ADDR_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB           = PORT_LSB + NUM_PORT_BITS;
  localparam int VALID_BIT          = LEAF_LSB + NUM_LEAF_BITS;

  // Credits: one per destination buffer slot, counter is one bit wider so
  // the full-buffer value fits.
  localparam int NUM_BRAM_ADDR_BITS = 7;
  localparam int CREDIT_BITS        = NUM_BRAM_ADDR_BITS + 1;
  localparam logic [CREDIT_BITS-1:0] CREDIT_INIT = CREDIT_BITS'(1 << NUM_BRAM_ADDR_BITS);
  localparam int FREESPACE_UPDATE_DEFAULT = 64;

  // Build a valid packet from its fields.
  function automatic logic [PACKET_BITS-1:0] pack_packet(
    input logic [NUM_LEAF_BITS-1:0] leaf,
    input logic [NUM_PORT_BITS-1:0] port,
    input logic [NUM_ADDR_BITS-1:0] addr,
    input logic [PAYLOAD_BITS-1:0]  payload
  );
    logic [PACKET_BITS-1:0] p;
    p = '0;
    p[VALID_BIT]                        = 1'b1;
    p[LEAF_LSB +: NUM_LEAF_BITS]        = leaf;
    p[PORT_LSB +: NUM_PORT_BITS]        = port;
    p[ADDR_LSB +: NUM_ADDR_BITS]        = addr;
    p[PAYLOAD_LSB +: PAYLOAD_BITS]      = payload;
    return p;
  endfunction

endpackage

// File: rtl/leaf_output_packetizer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, searching upward from
// the pointer with wrap. The pointer moves past the winner on each grant.
module rr_arbiter_n #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Pick the first requester at or above the pointer, wrapping around.
  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          ptr_d      = (idx + 1 == N) ? '0 : PTR_W'(idx + 1);
        end
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/leaf_output_packetizer.sv
// Output-side packetizer: arbitrates user output streams, tracks per-port
// destination credit, stamps leaf/port/address and registers one packet
// toward the BFT.
//
// Handshakes: a user word transfers when vld_user2interface[i] and
// ack_interface2user[i] are both high in the same cycle; a packet leaves the
// output register when it is valid, bft_ready is high and resend is low.
module leaf_output_packetizer
  import leaf_pkg::*;
#(
  parameter int NUM_OUT_PORTS         = 2,
  parameter int FREESPACE_UPDATE_SIZE = FREESPACE_UPDATE_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]               vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]               ack_interface2user,
  input  logic [NUM_OUT_PORTS*NUM_LEAF_BITS-1:0] dest_leaf_cfg,
  input  logic [NUM_OUT_PORTS*NUM_PORT_BITS-1:0] dest_port_cfg,
  input  logic                                   freespace_vld,
  input  logic [NUM_PORT_BITS-1:0]               freespace_port,
  input  logic                                   bft_ready,
  input  logic                                   resend,
  output logic [PACKET_BITS-1:0]                 dout_leaf_interface2bft,
  output logic                                   credit_err
);

  logic [PACKET_BITS-1:0]   out_q;
  logic [PACKET_BITS-1:0]   grant_pkt;
  logic [CREDIT_BITS-1:0]   credit_q [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_d [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] grant;
  logic                     load_ok;
  logic                     err_q;
  logic                     err_set;

  // The register can take a new packet when the link is not holding and the
  // current packet is absent or leaving; no grants while in reset.
  assign load_ok = !reset && !resend && (!out_q[VALID_BIT] || bft_ready);

  // A port may compete only when it has data and at least one credit.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      eligible[i] = vld_user2interface[i] && (credit_q[i] != '0);
  end

  rr_arbiter_n #(.N(NUM_OUT_PORTS)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (eligible),
    .en    (load_ok),
    .grant (grant)
  );

  assign ack_interface2user      = grant;
  assign dout_leaf_interface2bft = resend ? '0 : out_q;
  assign credit_err              = err_q;

  // Stamp the granted word with its configured destination and write address.
  always_comb begin
    grant_pkt = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant[i])
        grant_pkt = pack_packet(dest_leaf_cfg[i*NUM_LEAF_BITS +: NUM_LEAF_BITS],
                                dest_port_cfg[i*NUM_PORT_BITS +: NUM_PORT_BITS],
                                addr_q[i],
                                din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]);
    end
  end

  // Next credit per port: minus one per grant, plus an update on freespace,
  // clamped to the buffer depth with the overflow flagged.
  always_comb begin
    logic [CREDIT_BITS:0] sum;
    err_set = freespace_vld && (int'(freespace_port) >= NUM_OUT_PORTS);
    sum     = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      sum = {1'b0, credit_q[i]};
      if (freespace_vld && (int'(freespace_port) == i))
        sum = sum + (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE);
      if (grant[i])
        sum = sum - (CREDIT_BITS+1)'(1);
      if (sum > {1'b0, CREDIT_INIT}) begin
        credit_d[i] = CREDIT_INIT;
        err_set     = 1'b1;
      end else begin
        credit_d[i] = sum[CREDIT_BITS-1:0];
      end
    end
  end

  // Output register: load on grant, empty when the packet leaves, else hold.
  always_ff @(posedge clk) begin
    if (reset)                      out_q <= '0;
    else if (|grant)                out_q <= grant_pkt;
    else if (bft_ready && !resend)  out_q <= '0;
  end

  // Per-port credit and write-address counters, plus the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= CREDIT_INIT;
        addr_q[i]   <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= credit_d[i];
        if (grant[i]) addr_q[i] <= addr_q[i] + NUM_ADDR_BITS'(1);
      end
      err_q <= err_q | err_set;
    end
  end

endmodule

// File: tb/tb_leaf_output_packetizer.sv
// Bench for leaf_output_packetizer: directed scenarios with literal checks,
// plus a transaction-level model compared against the DUT every cycle.
module tb_leaf_output_packetizer;

  localparam int NP = 2;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            reset;
  logic [NP*32-1:0] din;
  logic [NP-1:0]   vld;
  logic [NP-1:0]   ack;
  logic [NP*5-1:0] leaf_cfg;
  logic [NP*4-1:0] port_cfg;
  logic            fs_vld;
  logic [3:0]      fs_port;
  logic            bft_ready;
  logic            resend;
  logic [48:0]     dout;
  logic            credit_err;

  always #5 clk = ~clk;

  leaf_output_packetizer #(.NUM_OUT_PORTS(NP), .FREESPACE_UPDATE_SIZE(64)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .dest_leaf_cfg           (leaf_cfg),
    .dest_port_cfg           (port_cfg),
    .freespace_vld           (fs_vld),
    .freespace_port          (fs_port),
    .bft_ready               (bft_ready),
    .resend                  (resend),
    .dout_leaf_interface2bft (dout),
    .credit_err              (credit_err)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- model + scoreboard ----------------
  logic [48:0] exp_q[$];
  int          m_credit [NP];
  int          m_addr   [NP];
  int          m_ptr;
  logic [48:0] m_out;
  logic        m_err;
  bit          model_live = 0;

  // Every cycle: predict the accept, compare, then advance the model as of
  // the coming rising edge.
  always @(negedge clk) begin
    int          g;
    int          p;
    logic [NP-1:0] e_ack;
    logic [48:0] e_dout;
    logic [48:0] pkt;
    #2;
    g = -1;
    if (!reset && !resend && (!m_out[48] || bft_ready)) begin
      for (int k = 0; k < NP; k++) begin
        p = (m_ptr + k) % NP;
        if (g < 0 && vld[p] && m_credit[p] > 0) g = p;
      end
    end
    e_ack = '0;
    if (g >= 0) e_ack[g] = 1'b1;
    e_dout = resend ? 49'd0 : m_out;

    if (model_live) begin
      chk("ack", ack, e_ack);
      chk("dout", dout, e_dout);
      chk("credit_err", credit_err, m_err);
      if (!reset && !resend && bft_ready && m_out[48]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got packet %h expected none queued", dout);
        end else begin
          pkt = exp_q.pop_front();
          chk("sb_pkt", dout, pkt);
        end
      end
    end

    if (reset) begin
      for (int i = 0; i < NP; i++) begin
        m_credit[i] = 128;
        m_addr[i]   = 0;
      end
      m_ptr = 0;
      m_out = '0;
      m_err = 1'b0;
      exp_q.delete();
      model_live = 1;
    end else begin
      if (g >= 0) begin
        pkt = {1'b1, leaf_cfg[g*5 +: 5], port_cfg[g*4 +: 4], 7'(m_addr[g]), din[g*32 +: 32]};
        m_out = pkt;
        exp_q.push_back(pkt);
        m_addr[g]   = (m_addr[g] + 1) % 128;
        m_credit[g] = m_credit[g] - 1;
        m_ptr       = (g + 1) % NP;
      end else if (bft_ready && !resend) begin
        m_out = '0;
      end
      if (fs_vld) begin
        if (int'(fs_port) >= NP) m_err = 1'b1;
        else begin
          m_credit[fs_port] = m_credit[fs_port] + 64;
          if (m_credit[fs_port] > 128) begin
            m_credit[fs_port] = 128;
            m_err = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offer words on the ports in v for ncyc cycles; count accepts and record
  // the addresses of accepted words as they appear on dout.
  task automatic send(input logic [NP-1:0] v, input int ncyc, output int nack,
                      output int first_addr, output int last_addr);
    bit prev = 0;
    nack = 0;
    first_addr = -1;
    last_addr  = -1;
    for (int c = 0; c < ncyc; c++) begin
      vld = v;
      din = {$urandom, $urandom};
      #1;
      if (prev) begin
        if (first_addr < 0) first_addr = int'(dout[38:32]);
        last_addr = int'(dout[38:32]);
      end
      prev = |ack;
      nack += $countones(ack);
      @(negedge clk);
    end
    vld = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    vld   = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic freespace(input logic [3:0] port);
    fs_vld  = 1'b1;
    fs_port = port;
    @(negedge clk);
    fs_vld  = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n, fa, la;
    reset     = 1'b1;
    vld       = '0;
    din       = '0;
    leaf_cfg  = {5'd7, 5'd3};
    port_cfg  = {4'd9, 4'd2};
    fs_vld    = 1'b0;
    fs_port   = '0;
    bft_ready = 1'b1;
    resend    = 1'b0;
    repeat (2) @(negedge clk);

    // Single port: first word, latency and address stamping.
    reset = 1'b0;
    vld = 2'b01;
    din[31:0] = 32'hA5A5_0001;
    #1;
    chk("rst_dout", dout, 49'd0);
    chk("rst_err", credit_err, 1'b0);
    chk("t1_ack0", ack, 2'b01);
    @(negedge clk);
    din[31:0] = 32'hA5A5_0002;
    #1;
    chk("t1_pkt0", dout, {1'b1, 5'd3, 4'd2, 7'd0, 32'hA5A5_0001});
    chk("t1_ack1", ack, 2'b01);
    @(negedge clk);
    vld = '0;
    #1 chk("t1_pkt1", dout, {1'b1, 5'd3, 4'd2, 7'd1, 32'hA5A5_0002});
    @(negedge clk);
    #1 chk("t1_idle", dout, 49'd0);

    // Round-robin: pointer sits at port 1 after the port-0 grants.
    @(negedge clk);
    vld = 2'b11;
    din = {32'h1111_0000, 32'h2222_0000};
    #1 chk("rr_ack_a", ack, 2'b10);
    @(negedge clk);
    din = {32'h1111_0001, 32'h2222_0001};
    #1;
    chk("rr_ack_b", ack, 2'b01);
    chk("rr_p1_addr0", dout[38:32], 7'd0);
    chk("rr_p1_leaf", dout[47:43], 5'd7);
    @(negedge clk);
    #1;
    chk("rr_ack_c", ack, 2'b10);
    chk("rr_p0_addr2", dout[38:32], 7'd2);
    @(negedge clk);
    #1 chk("rr_p1_addr1", dout[38:32], 7'd1);
    repeat (3) begin
      @(negedge clk);
      din = {$urandom, $urandom};
    end
    @(negedge clk);
    vld = '0;
    @(negedge clk);

    // Credit exhaustion on port 0, then one freespace update.
    pulse_reset();
    send(2'b01, 140, n, fa, la);
    chk("ex_count128", n, 128);
    chk("ex_last_addr127", la, 127);
    vld = 2'b01;
    #1 chk("ex_ack_blocked", ack, 2'b00);
    freespace(4'd0);
    send(2'b01, 80, n, fa, la);
    chk("ex_count64", n, 64);
    chk("ex_wrap_addr0", fa, 0);
    chk("ex_last_addr63", la, 63);

    // Backpressure, config change while held, and resend.
    pulse_reset();
    vld = 2'b01;
    din[31:0] = 32'h0BAD_F00D;
    @(negedge clk);
    bft_ready = 1'b0;
    #1;
    chk("bp_ack", ack, 2'b00);
    chk("bp_hold0", dout, {1'b1, 5'd3, 4'd2, 7'd0, 32'h0BAD_F00D});
    leaf_cfg[4:0] = 5'd9;
    @(negedge clk);
    #1;
    chk("bp_ack1", ack, 2'b00);
    chk("bp_hold1", dout, {1'b1, 5'd3, 4'd2, 7'd0, 32'h0BAD_F00D});
    resend = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rs_dout0", dout, 49'd0);
      chk("rs_ack0", ack, 2'b00);
    end
    @(negedge clk);
    resend = 1'b0;
    #1 chk("rs_back", dout, {1'b1, 5'd3, 4'd2, 7'd0, 32'h0BAD_F00D});
    @(negedge clk);
    bft_ready = 1'b1;
    vld = '0;
    #1 chk("rs_still", dout, {1'b1, 5'd3, 4'd2, 7'd0, 32'h0BAD_F00D});
    @(negedge clk);
    #1 chk("rs_gone", dout, 49'd0);
    vld = 2'b01;
    @(negedge clk);
    vld = '0;
    #1 chk("cfg_new_leaf", dout[47:43], 5'd9);
    leaf_cfg[4:0] = 5'd3;
    @(negedge clk);

    // Simultaneous grant and freespace on port 1, then clamping.
    pulse_reset();
    send(2'b10, 118, n, fa, la);
    chk("sim_prefill", n, 118);
    vld = 2'b10;
    fs_vld = 1'b1;
    fs_port = 4'd1;
    #1 chk("sim_ack", ack, 2'b10);
    @(negedge clk);
    fs_vld = 1'b0;
    send(2'b10, 90, n, fa, la);
    chk("sim_credit73", n, 73);
    freespace(4'd1);
    freespace(4'd1);
    #1 chk("clamp_at128_no_err", credit_err, 1'b0);
    send(2'b10, 28, n, fa, la);
    chk("drain28", n, 28);
    freespace(4'd1);
    #1 chk("clamp_err", credit_err, 1'b1);
    send(2'b10, 140, n, fa, la);
    chk("clamp_count128", n, 128);

    // Freespace for a port that does not exist.
    pulse_reset();
    #1 chk("oor_err_clear", credit_err, 1'b0);
    freespace(4'd2);
    #1 chk("oor_err", credit_err, 1'b1);
    @(negedge clk);
    #1 chk("oor_sticky", credit_err, 1'b1);

    // Reset while a packet is held.
    send(2'b11, 5, n, fa, la);
    bft_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    vld = 2'b11;
    bft_ready = 1'b1;
    #1 chk("mr_ack_in_reset", ack, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    vld = '0;
    #1;
    chk("mr_dout0", dout, 49'd0);
    chk("mr_err0", credit_err, 1'b0);
    @(negedge clk);
    vld = 2'b11;
    din = {32'hBEEF_0001, 32'hCAFE_0001};
    #1 chk("mr_ptr0", ack, 2'b01);
    @(negedge clk);
    vld = '0;
    #1 chk("mr_pkt", dout, {1'b1, 5'd3, 4'd2, 7'd0, 32'hCAFE_0001});

    repeat (4) @(negedge clk);
    #3 chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: run did not complete by %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
